// File: rtl/bram_arb_pkg.sv
// Shared constants for the single-port BRAM access arbiter.
package bram_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_DEF = 1;

    // Requester IDs; they also index the per-requester packed arrays.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // The requester that did not win last time.
    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone eligible requester wins outright,
// a tie goes to whichever side did not win last.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic elig_a,
    input  logic elig_b,
    input  logic last_winner,
    output logic win_valid,
    output logic win_id
);

    // Pick the winner for this cycle.
    always_comb begin
        win_valid = elig_a | elig_b;
        win_id    = REQ_A;
        if (elig_a && elig_b) begin
            win_id = other_id(last_winner);
        end else if (elig_b) begin
            win_id = REQ_B;
        end
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares one single-port BRAM between requesters A and B. One access is
// issued per cycle from registers; read data is returned to the issuing
// side, tagged through a pipeline of depth RD_LAT. bram_dout is sampled
// on the RD_LAT-th clock edge after the edge that drives bram_en high.
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    // Per-requester views, indexed by REQ_A / REQ_B.
    logic [1:0]             req_v;
    logic [1:0]             we_v;
    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][DATA_W-1:0] wdata_v;
    logic [1:0]             gnt_q;
    logic [1:0]             elig;

    logic win_valid;
    logic win_id;
    logic last_winner;

    // Read-tag pipeline: stage 0 lines up with the cycle bram_en is high.
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] tag_pipe;
    logic              rd_hit;
    logic              rd_tag;

    assign req_v   = {b_req, a_req};
    assign we_v    = {b_we, a_we};
    assign addr_v  = {b_addr, a_addr};
    assign wdata_v = {b_wdata, a_wdata};

    // A req still high while its gnt is showing is the stale copy of the
    // request just served, so it is masked for one cycle.
    assign elig = req_v & ~gnt_q;

    rr_arb2 u_rr (
        .elig_a      (elig[REQ_A]),
        .elig_b      (elig[REQ_B]),
        .last_winner (last_winner),
        .win_valid   (win_valid),
        .win_id      (win_id)
    );

    assign a_gnt = gnt_q[REQ_A];
    assign b_gnt = gnt_q[REQ_B];

    // Command registers: grant pulse and BRAM pins for the winner.
    // Address and data hold when nothing is issued.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            gnt_q       <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            last_winner <= REQ_B;
        end else begin
            gnt_q   <= '0;
            bram_en <= win_valid;
            bram_we <= win_valid & we_v[win_id];
            if (win_valid) begin
                gnt_q[win_id] <= 1'b1;
                bram_addr     <= addr_v[win_id];
                bram_din      <= wdata_v[win_id];
                last_winner   <= win_id;
            end
        end
    end

    // Shift the requester tag of each issued read towards the return point.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= win_valid & ~we_v[win_id];
            tag_pipe[0] <= win_id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rd_hit = vld_pipe[RD_LAT-1];
    assign rd_tag = tag_pipe[RD_LAT-1];

    // Steer returning read data to the tagged side; the other side holds.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= rd_hit & (rd_tag == REQ_A);
            b_rvalid <= rd_hit & (rd_tag == REQ_B);
            if (rd_hit && rd_tag == REQ_A) a_rdata <= bram_dout;
            if (rd_hit && rd_tag == REQ_B) b_rdata <= bram_dout;
        end
    end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: directed vector table, hand sequences for
// alternation / reset / RD_LAT=3, and a randomized run against a rule model.
module tb_bram_access_arbiter;
    import bram_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    // Main DUT (RD_LAT = 1)
    logic a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    bram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // BRAM model for latency 1: data for the enabled address is presented
    // during the enable cycle and captured by the DUT on the next edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic mem_clr;
    assign bram_dout = mem[bram_addr];
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else if (bram_en && bram_we) begin
            mem[bram_addr] <= bram_din;
        end
    end

    // Second DUT (RD_LAT = 3) with a read-only pattern BRAM
    logic x3_a_req, x3_a_we, x3_b_req, x3_b_we;
    logic [AW-1:0] x3_a_addr, x3_b_addr;
    logic [DW-1:0] x3_a_wdata, x3_b_wdata;
    logic x3_a_gnt, x3_a_rvalid, x3_b_gnt, x3_b_rvalid;
    logic [DW-1:0] x3_a_rdata, x3_b_rdata;
    logic x3_en, x3_we;
    logic [AW-1:0] x3_addr;
    logic [DW-1:0] x3_din, x3_dout, x3_s1, x3_s2;

    bram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .CLK(CLK), .RSTN(RSTN),
        .a_req(x3_a_req), .a_we(x3_a_we), .a_addr(x3_a_addr), .a_wdata(x3_a_wdata),
        .a_gnt(x3_a_gnt), .a_rvalid(x3_a_rvalid), .a_rdata(x3_a_rdata),
        .b_req(x3_b_req), .b_we(x3_b_we), .b_addr(x3_b_addr), .b_wdata(x3_b_wdata),
        .b_gnt(x3_b_gnt), .b_rvalid(x3_b_rvalid), .b_rdata(x3_b_rdata),
        .bram_en(x3_en), .bram_we(x3_we), .bram_addr(x3_addr),
        .bram_din(x3_din), .bram_dout(x3_dout)
    );

    always @(posedge CLK) begin
        if (x3_en) x3_s1 <= {23'h0, x3_addr} ^ 32'h5A00_0000;
        x3_s2 <= x3_s1;
    end
    assign x3_dout = x3_s2;

    // Requesters must keep we/addr/wdata stable while a live request waits.
    logic pa_live, pa_we, pb_live, pb_we;
    logic [AW-1:0] pa_addr, pb_addr;
    logic [DW-1:0] pa_wd, pb_wd;
    always @(posedge CLK) begin
        if (!RSTN) begin
            pa_live <= 1'b0;
            pb_live <= 1'b0;
        end else begin
            if (pa_live && !a_gnt && a_req)
                assert (a_we == pa_we && a_addr == pa_addr && a_wdata == pa_wd)
                else $error("A request fields changed while pending");
            if (pb_live && !b_gnt && b_req)
                assert (b_we == pb_we && b_addr == pb_addr && b_wdata == pb_wd)
                else $error("B request fields changed while pending");
            pa_live <= a_req && !a_gnt;
            pb_live <= b_req && !b_gnt;
            pa_we <= a_we; pa_addr <= a_addr; pa_wd <= a_wdata;
            pb_we <= b_we; pb_addr <= b_addr; pb_wd <= b_wdata;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst_a_gnt", a_gnt, 0);       chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rv", a_rvalid, 0);     chk("rst_b_rv", b_rvalid, 0);
        chk("rst_a_rd", a_rdata, 0);      chk("rst_b_rd", b_rdata, 0);
        chk("rst_en", bram_en, 0);        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);    chk("rst_din", bram_din, 0);
        chk("rst3_a_gnt", x3_a_gnt, 0);   chk("rst3_b_gnt", x3_b_gnt, 0);
        chk("rst3_a_rv", x3_a_rvalid, 0); chk("rst3_b_rv", x3_b_rvalid, 0);
        chk("rst3_a_rd", x3_a_rdata, 0);  chk("rst3_b_rd", x3_b_rdata, 0);
        chk("rst3_en", x3_en, 0);         chk("rst3_we", x3_we, 0);
        chk("rst3_addr", x3_addr, 0);     chk("rst3_din", x3_din, 0);
    endtask

    // Directed vector table: inputs held before an edge, outputs expected after it.
    typedef struct {
        logic ar, aw; logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic br, bw; logic [AW-1:0] ba; logic [DW-1:0] bd;
        logic eag, ebg, een, ewe; logic [AW-1:0] eaddr; logic [DW-1:0] edin;
        logic earv; logic [DW-1:0] eard; logic ebrv; logic [DW-1:0] ebrd;
    } vec_t;
    vec_t vt [10];

    // Reference model state for the random run.
    typedef struct { logic side; logic [DW-1:0] data; int due; } rd_t;
    rd_t pend [$];
    logic [DW-1:0] shadow [0:15];
    logic pg_a, pg_b, last_b;
    int cyc;
    logic e_ag, e_bg, e_en, e_we, e_arv, e_brv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_ard, e_brd;

    // One edge of the arbitration rules applied to the inputs now presented.
    task automatic model_step();
        logic ea, eb, wv, wb, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        rd_t p;
        ea = a_req && !pg_a;
        eb = b_req && !pg_b;
        wv = ea || eb;
        wb = (ea && eb) ? !last_b : eb;
        e_arv = 1'b0;
        e_brv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (p.side) begin e_brv = 1'b1; e_brd = p.data; end
            else        begin e_arv = 1'b1; e_ard = p.data; end
        end
        e_en = wv;
        e_we = 1'b0;
        if (wv) begin
            we = wb ? b_we : a_we;
            ad = wb ? b_addr : a_addr;
            wd = wb ? b_wdata : a_wdata;
            e_we = we; e_addr = ad; e_din = wd;
            if (we) shadow[ad[3:0]] = wd;
            else pend.push_back('{wb, shadow[ad[3:0]], cyc + 1});
            last_b = wb;
        end
        pg_a = wv && !wb;
        pg_b = wv && wb;
        e_ag = pg_a;
        e_bg = pg_b;
        cyc++;
    endtask

    task automatic new_req(output logic r, output logic w,
                           output logic [AW-1:0] ad, output logic [DW-1:0] wd);
        r  = $urandom_range(0, 1) == 1;
        w  = $urandom_range(0, 1) == 1;
        ad = AW'($urandom_range(0, 15));
        wd = $urandom;
    endtask

    initial begin
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        x3_a_req = 0; x3_a_we = 0; x3_a_addr = 0; x3_a_wdata = 0;
        x3_b_req = 0; x3_b_we = 0; x3_b_addr = 0; x3_b_wdata = 0;
        RSTN = 0;
        mem_clr = 1;

        //          A: req we addr   wdata         B: req we addr   wdata   | ag  bg  en  we  addr   din           arv ard           brv brd
        vt[0] = '{1'b1,1'b1,9'h010,32'hDEADBEEF, 1'b0,1'b0,9'h000,32'h0,  1'b1,1'b0,1'b1,1'b1,9'h010,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0};
        vt[1] = '{1'b1,1'b1,9'h010,32'hDEADBEEF, 1'b0,1'b0,9'h000,32'h0,  1'b0,1'b0,1'b0,1'b0,9'h010,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0};
        vt[2] = '{1'b1,1'b0,9'h010,32'h0,        1'b0,1'b0,9'h000,32'h0,  1'b1,1'b0,1'b1,1'b0,9'h010,32'h0,        1'b0,32'h0,        1'b0,32'h0};
        vt[3] = '{1'b1,1'b0,9'h010,32'h0,        1'b0,1'b0,9'h000,32'h0,  1'b0,1'b0,1'b0,1'b0,9'h010,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h0};
        vt[4] = '{1'b0,1'b0,9'h000,32'h0,        1'b1,1'b1,9'h030,32'h33, 1'b0,1'b1,1'b1,1'b1,9'h030,32'h33,       1'b0,32'hDEADBEEF, 1'b0,32'h0};
        vt[5] = '{1'b0,1'b0,9'h000,32'h0,        1'b1,1'b1,9'h030,32'h33, 1'b0,1'b0,1'b0,1'b0,9'h030,32'h33,       1'b0,32'hDEADBEEF, 1'b0,32'h0};
        vt[6] = '{1'b1,1'b1,9'h020,32'h1,        1'b1,1'b0,9'h020,32'h0,  1'b1,1'b0,1'b1,1'b1,9'h020,32'h1,        1'b0,32'hDEADBEEF, 1'b0,32'h0};
        vt[7] = '{1'b1,1'b1,9'h020,32'h1,        1'b1,1'b0,9'h020,32'h0,  1'b0,1'b1,1'b1,1'b0,9'h020,32'h0,        1'b0,32'hDEADBEEF, 1'b0,32'h0};
        vt[8] = '{1'b0,1'b0,9'h000,32'h0,        1'b1,1'b0,9'h020,32'h0,  1'b0,1'b0,1'b0,1'b0,9'h020,32'h0,        1'b0,32'hDEADBEEF, 1'b1,32'h1};
        vt[9] = '{1'b0,1'b0,9'h000,32'h0,        1'b0,1'b0,9'h000,32'h0,  1'b0,1'b0,1'b0,1'b0,9'h020,32'h0,        1'b0,32'hDEADBEEF, 1'b0,32'h1};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_rst();
        mem_clr = 0;
        RSTN = 1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            a_req = vt[i].ar; a_we = vt[i].aw; a_addr = vt[i].aa; a_wdata = vt[i].ad;
            b_req = vt[i].br; b_we = vt[i].bw; b_addr = vt[i].ba; b_wdata = vt[i].bd;
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("v%0d_a_gnt", i), a_gnt, vt[i].eag);
            chk($sformatf("v%0d_b_gnt", i), b_gnt, vt[i].ebg);
            chk($sformatf("v%0d_en", i), bram_en, vt[i].een);
            chk($sformatf("v%0d_we", i), bram_we, vt[i].ewe);
            chk($sformatf("v%0d_addr", i), bram_addr, vt[i].eaddr);
            chk($sformatf("v%0d_din", i), bram_din, vt[i].edin);
            chk($sformatf("v%0d_a_rv", i), a_rvalid, vt[i].earv);
            chk($sformatf("v%0d_a_rd", i), a_rdata, vt[i].eard);
            chk($sformatf("v%0d_b_rv", i), b_rvalid, vt[i].ebrv);
            chk($sformatf("v%0d_b_rd", i), b_rdata, vt[i].ebrd);
        end

        // Both sides hold reads: grants alternate starting with A
        a_req = 1; a_we = 0; a_addr = 9'h010; a_wdata = 0;
        b_req = 1; b_we = 0; b_addr = 9'h030; b_wdata = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("alt_a_gnt", a_gnt, (k % 2 == 0));
            chk("alt_b_gnt", b_gnt, (k % 2 == 1));
            chk("alt_en", bram_en, 1);
            chk("alt_addr", bram_addr, (k % 2 == 0) ? 9'h010 : 9'h030);
            chk("alt_a_rv", a_rvalid, (k % 2 == 1));
            chk("alt_b_rv", b_rvalid, (k % 2 == 0) && (k > 0));
            if (k % 2 == 1) chk("alt_a_rd", a_rdata, 32'hDEADBEEF);
            else if (k > 0) chk("alt_b_rd", b_rdata, 32'h33);
        end
        a_req = 0;
        b_req = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("alt_tail_b_rv", b_rvalid, 1);
        chk("alt_tail_b_rd", b_rdata, 32'h33);
        chk("alt_tail_en", bram_en, 0);

        // Reset pulse while a B read is in flight
        b_req = 1; b_we = 0; b_addr = 9'h030; b_wdata = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("mid_b_gnt", b_gnt, 1);
        b_req = 0;
        RSTN = 0;
        #1;
        chk_rst();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("mid_b_rv", b_rvalid, 0);
            chk("mid_a_rv", a_rvalid, 0);
            chk("mid_en", bram_en, 0);
        end

        // Randomized run against the rule model (addresses 0..15 are still zero)
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        pg_a = 0; pg_b = 0; last_b = 1; cyc = 0;
        e_addr = '0; e_din = '0; e_ard = '0; e_brd = '0;
        for (int n = 0; n < 600; n++) begin
            if (n >= 594) begin
                a_req = 0;
                b_req = 0;
            end else begin
                if (a_req && pg_a) new_req(a_req, a_we, a_addr, a_wdata);
                else if (a_req) begin if ($urandom_range(0, 15) == 0) a_req = 0; end
                else new_req(a_req, a_we, a_addr, a_wdata);
                if (b_req && pg_b) new_req(b_req, b_we, b_addr, b_wdata);
                else if (b_req) begin if ($urandom_range(0, 15) == 0) b_req = 0; end
                else new_req(b_req, b_we, b_addr, b_wdata);
            end
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            chk("rnd_a_gnt", a_gnt, e_ag);
            chk("rnd_b_gnt", b_gnt, e_bg);
            chk("rnd_en", bram_en, e_en);
            chk("rnd_we", bram_we, e_we);
            chk("rnd_addr", bram_addr, e_addr);
            chk("rnd_din", bram_din, e_din);
            chk("rnd_a_rv", a_rvalid, e_arv);
            chk("rnd_a_rd", a_rdata, e_ard);
            chk("rnd_b_rv", b_rvalid, e_brv);
            chk("rnd_b_rd", b_rdata, e_brd);
        end
        chk("rnd_drained", pend.size(), 0);

        // RD_LAT = 3: single A read returns 4 cycles after the request edge
        x3_a_req = 1; x3_a_we = 0; x3_a_addr = 9'h055; x3_a_wdata = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            x3_a_req = 0;
            chk($sformatf("lat3_gnt_c%0d", k), x3_a_gnt, (k == 1));
            chk($sformatf("lat3_en_c%0d", k), x3_en, (k == 1));
            chk($sformatf("lat3_rv_c%0d", k), x3_a_rvalid, (k == 4));
            chk($sformatf("lat3_brv_c%0d", k), x3_b_rvalid, 0);
            if (k == 4) chk("lat3_rd", x3_a_rdata, 32'h5A00_0055);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
